// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration, rounding modes and the round/saturate helper.
package fpga_cfg_pkg;

   localparam int unsigned FP_WIDTH         = 32;
   localparam int unsigned FP_QFRAC         = 16;
   localparam int unsigned FP_MUL_LATENCY   = 3;
   localparam int unsigned FP_MUL_LANES_MAX = 8;

   // The helper works on a fixed maximum width so any caller up to 64-bit operands can share it.
   localparam int unsigned FX_WMAX = 64;
   localparam int unsigned FX_PMAX = 2 * FX_WMAX;
   localparam int unsigned FX_EW   = FX_PMAX + 1;

   typedef enum logic [1:0] {
      FX_RND_TRUNC   = 2'd0,
      FX_RND_HALF_UP = 2'd1,
      FX_RND_CONV    = 2'd2,
      FX_RND_RSVD    = 2'd3
   } fx_rnd_e;

   // Round a sign-extended product by qfrac bits and saturate to width bits; returns {ovf, q}.
   function automatic logic [FX_WMAX:0] fx_sat_round(input logic signed [FX_PMAX-1:0] p,
                                                     input fx_rnd_e                   mode,
                                                     input logic [7:0]                width,
                                                     input logic [7:0]                qfrac);
      logic signed [FX_EW-1:0] pe;
      logic signed [FX_EW-1:0] half;
      logic signed [FX_EW-1:0] sum;
      logic signed [FX_EW-1:0] q;
      logic signed [FX_EW-1:0] qmax;
      logic signed [FX_EW-1:0] qmin;
      logic        [FX_EW-1:0] frac_mask;
      logic                    tie;
      logic                    ovf;
      logic [FX_WMAX-1:0]      r;

      // One extra bit of headroom keeps the rounding add from wrapping.
      pe        = {p[FX_PMAX-1], p};
      half      = $signed(FX_EW'(1) << (qfrac - 8'd1));
      frac_mask = (FX_EW'(1) << qfrac) - FX_EW'(1);
      tie       = ((pe & frac_mask) == half);

      case (mode)
         FX_RND_HALF_UP: sum = pe + half;
         // On an exact tie only round up when the floor result is odd.
         FX_RND_CONV:    sum = (tie && !pe[qfrac]) ? pe : pe + half;
         default:        sum = pe;
      endcase

      q    = sum >>> qfrac;
      qmax = $signed((FX_EW'(1) << (width - 8'd1)) - FX_EW'(1));
      qmin = -$signed(FX_EW'(1) << (width - 8'd1));

      if (q > qmax) begin
         ovf = 1'b1;
         r   = qmax[FX_WMAX-1:0];
      end else if (q < qmin) begin
         ovf = 1'b1;
         r   = qmin[FX_WMAX-1:0];
      end else begin
         ovf = 1'b0;
         r   = q[FX_WMAX-1:0];
      end
      return {ovf, r};
   endfunction

endpackage

// File: rtl/fx_mul_lane.sv
// Single-lane signed fixed-point multiply with rounding and saturation, LATENCY register stages.
module fx_mul_lane
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned WIDTH   = FP_WIDTH,
   parameter int unsigned QFRAC   = FP_QFRAC,
   parameter int unsigned LATENCY = FP_MUL_LATENCY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  fx_rnd_e          mode_i,
   output logic [WIDTH-1:0] result_o,
   output logic             ovf_o,
   output logic             ovf_nxt_c
);

   localparam int unsigned PW = 2 * WIDTH;

   logic signed [PW-1:0]  prod_fin;
   fx_rnd_e               mode_fin;
   logic [FX_WMAX:0]      sr_c;
   logic                  unused_sr;
   logic [WIDTH-1:0]      result_q;
   logic                  ovf_q;

   if (LATENCY == 1) begin : g_l1
      // Single stage: multiply straight from the ports into the output register.
      assign prod_fin = PW'($signed(a_i)) * PW'($signed(b_i));
      assign mode_fin = mode_i;
   end else begin : g_ln
      logic signed [WIDTH-1:0] a_q;
      logic signed [WIDTH-1:0] b_q;
      fx_rnd_e                 mode_q;

      // Stage 0: capture operands and rounding mode.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= FX_RND_TRUNC;
         end else if (en_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            mode_q <= mode_i;
         end
      end

      if (LATENCY == 2) begin : g_l2
         assign prod_fin = PW'(a_q) * PW'(b_q);
         assign mode_fin = mode_q;
      end else begin : g_l3
         localparam int unsigned D = LATENCY - 2;
         logic signed [PW-1:0] p_q [D];
         fx_rnd_e              m_q [D];

         // Stage 1 registers the full product; later stages just delay it to the output.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < D; k++) begin
                  p_q[k] <= '0;
                  m_q[k] <= FX_RND_TRUNC;
               end
            end else if (en_i) begin
               p_q[0] <= PW'(a_q) * PW'(b_q);
               m_q[0] <= mode_q;
               for (int k = 1; k < D; k++) begin
                  p_q[k] <= p_q[k-1];
                  m_q[k] <= m_q[k-1];
               end
            end
         end

         assign prod_fin = p_q[D-1];
         assign mode_fin = m_q[D-1];
      end
   end

   assign sr_c      = fx_sat_round(FX_PMAX'(prod_fin), mode_fin, 8'(WIDTH), 8'(QFRAC));
   assign unused_sr = ^sr_c;
   assign ovf_nxt_c = sr_c[FX_WMAX];

   // Final stage: rounded, saturated result and its overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else if (en_i) begin
         result_q <= sr_c[WIDTH-1:0];
         ovf_q    <= sr_c[FX_WMAX];
      end
   end

   assign result_o = result_q;
   assign ovf_o    = ovf_q;

endmodule

// File: rtl/fx_mul_pipe.sv
// Multi-lane fixed-point multiplier with valid/ready handshake, tag pass-through and sticky overflow.
module fx_mul_pipe
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned WIDTH   = FP_WIDTH,
   parameter int unsigned QFRAC   = FP_QFRAC,
   parameter int unsigned LANES   = 1,
   parameter int unsigned LATENCY = FP_MUL_LATENCY,
   parameter int unsigned TAGW    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [LANES*WIDTH-1:0] a_i,
   input  logic [LANES*WIDTH-1:0] b_i,
   input  logic [1:0]             rnd_mode_i,
   input  logic [TAGW-1:0]        tag_in_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [LANES*WIDTH-1:0] result_o,
   output logic [LANES-1:0]       ovf_o,
   output logic [TAGW-1:0]        tag_out_o,
   output logic                   ovf_sticky_o,
   input  logic                   ovf_clr_i
);

   logic               en_c;
   logic [LATENCY-1:0] v_q;
   logic [LATENCY-1:0] v_d;
   logic [TAGW-1:0]    tag_q [LATENCY];
   logic [LANES-1:0]   ovf_nxt_c;
   logic               sticky_q;
   logic               sticky_d;

   // Whole pipeline advances unless the output is held by the consumer.
   assign en_c       = !v_q[LATENCY-1] || out_ready_i;
   assign in_ready_o = en_c;

   // Valid bits shift alongside the data; bubbles are kept.
   always_comb begin
      v_d    = '0;
      v_d[0] = in_valid_i;
      for (int k = 1; k < LATENCY; k++) begin
         v_d[k] = v_q[k-1];
      end
   end

   // Valid and tag pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            tag_q[k] <= '0;
         end
      end else if (en_c) begin
         v_q      <= v_d;
         tag_q[0] <= tag_in_i;
         for (int k = 1; k < LATENCY; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fx_mul_lane #(
         .WIDTH   (WIDTH),
         .QFRAC   (QFRAC),
         .LATENCY (LATENCY)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (en_c),
         .a_i       (a_i[l*WIDTH +: WIDTH]),
         .b_i       (b_i[l*WIDTH +: WIDTH]),
         .mode_i    (fx_rnd_e'(rnd_mode_i)),
         .result_o  (result_o[l*WIDTH +: WIDTH]),
         .ovf_o     (ovf_o[l]),
         .ovf_nxt_c (ovf_nxt_c[l])
      );
   end

   // Sticky sets as an overflowing item lands in the output stage; a set beats a clear.
   always_comb begin
      sticky_d = sticky_q && !ovf_clr_i;
      if (en_c && v_d[LATENCY-1] && (|ovf_nxt_c)) begin
         sticky_d = 1'b1;
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign out_valid_o  = v_q[LATENCY-1];
   assign tag_out_o    = tag_q[LATENCY-1];
   assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Scoreboard bench for fx_mul_pipe: four lanes, Q16.16, three-stage pipeline.
module tb_fx_mul_pipe;

   localparam int W   = 32;
   localparam int L   = 4;
   localparam int LAT = 3;
   localparam int TW  = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid;
   logic           in_ready;
   logic [L*W-1:0] a;
   logic [L*W-1:0] b;
   logic [1:0]     rnd_mode;
   logic [TW-1:0]  tag_in;
   logic           out_valid;
   logic           out_ready;
   logic [L*W-1:0] result;
   logic [L-1:0]   ovf;
   logic [TW-1:0]  tag_out;
   logic           ovf_sticky;
   logic           ovf_clr;

   always #5 clk = ~clk;

   fx_mul_pipe #(
      .WIDTH(W), .QFRAC(16), .LANES(L), .LATENCY(LAT), .TAGW(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .rnd_mode_i(rnd_mode), .tag_in_i(tag_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
      .ovf_o(ovf), .tag_out_o(tag_out), .ovf_sticky_o(ovf_sticky), .ovf_clr_i(ovf_clr)
   );

   typedef struct {
      logic [L*W-1:0] res;
      logic [L-1:0]   ovf;
      logic [TW-1:0]  tag;
      int             acc;
      bit             lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   seen = 0;
   bit   bp_mode = 1'b0;
   bit   held = 1'b0;
   logic [L*W-1:0] h_res;
   logic [TW-1:0]  h_tag;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rep(input logic [31:0] x);
      return {4{x}};
   endfunction

   // Reference: 64-bit integer multiply, floor/half-up/even rounding, clamp to 32 bits.
   function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
      longint p, fl, q;
      p  = longint'($signed(x)) * longint'($signed(y));
      fl = p >>> 16;
      if (m == 2'd1 || (m == 2'd2 && (p & 64'hFFFF) != 64'h8000)) q = (p + 64'sd32768) >>> 16;
      else if (m == 2'd2) q = fl + (fl & 64'sd1);
      else q = fl;
      if (q > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
      if (q < -64'sd2147483648) return {1'b1, 32'h80000000};
      return {1'b0, q[31:0]};
   endfunction

   // Random consumer backpressure while bp_mode is set.
   always @(negedge clk) begin
      if (bp_mode) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
   end

   // Monitor: latency on first presentation, stability while stalled, compare on consume.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         held = 1'b0;
      end else if (out_valid) begin
         seen++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got tag %h want no output", tag_out);
         end else begin
            if (held) begin
               chk("hold_result", result, h_res);
               chk("hold_tag", tag_out, h_tag);
            end else if (sb[0].lat) begin
               chk("latency", cyc - sb[0].acc, LAT);
            end
            if (out_ready) begin
               mon_e = sb.pop_front();
               chk("result", result, mon_e.res);
               chk("ovf", ovf, mon_e.ovf);
               chk("tag_out", tag_out, mon_e.tag);
               held = 1'b0;
            end else begin
               chk("stall_in_ready", in_ready, 0);
               held  = 1'b1;
               h_res = result;
               h_tag = tag_out;
            end
         end
      end
   end

   task automatic send(input logic [127:0] va, input logic [127:0] vb, input logic [1:0] m,
                       input logic [7:0] t, input logic [127:0] r, input logic [3:0] o,
                       output int waits);
      exp_t e;
      waits = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      rnd_mode = m;
      tag_in   = t;
      forever begin
         #4;
         if (in_ready) begin
            e.res = r; e.ovf = o; e.tag = t; e.acc = cyc; e.lat = !bp_mode;
            sb.push_back(e);
            @(posedge clk);
            break;
         end
         @(posedge clk);
         waits++;
         if (waits > 500) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no in_ready want in_ready within 500 cycles");
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      @(negedge clk);
      #3;
   endtask

   logic [31:0]  rnd_a [11] = '{32'h1, 32'h1, 32'h1, 32'h3, 32'h3, 32'h3,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 32'h5};
   logic [1:0]   rnd_m [11] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
   logic [31:0]  rnd_r [11] = '{32'h0, 32'h1, 32'h0, 32'h1, 32'h2, 32'h2,
                                32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 32'h2};
   logic [31:0]  rx, ry;
   logic [32:0]  rr;
   logic [127:0] va, vb, vr;
   logic [3:0]   vo;
   int           w;

   initial begin
      in_valid = 1'b0; a = '0; b = '0; rnd_mode = 2'd0; tag_in = '0;
      ovf_clr = 1'b0; out_ready = 1'b1;

      // Reset values with no clock edge required.
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_tag_out", tag_out, 0);
      chk("rst_sticky", ovf_sticky, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1.5 * 2.0 = 3.0
      send(rep(32'h00018000), rep(32'h00020000), 2'd0, 8'h01, rep(32'h00030000), 4'h0, w);
      idle();
      drain();

      // Back-to-back: (i+1) * 2.0
      for (int i = 0; i < 20; i++) begin
         send(rep(32'((i + 1) << 16)), rep(32'h00020000), 2'd1, 8'(8'h10 + i),
              rep(32'((i + 1) << 17)), 4'h0, w);
         chk("b2b_ready", w, 0);
      end
      idle();
      drain();

      // Rounding modes at and around the half-LSB tie.
      for (int i = 0; i < 11; i++) begin
         send(rep(rnd_a[i]), rep(32'h00008000), rnd_m[i], 8'(8'h40 + i), rep(rnd_r[i]), 4'h0, w);
      end
      idle();
      drain();
      chk("sticky_clean", ovf_sticky, 0);

      // Saturation, mixed per lane then all lanes negative.
      send({32'h0, 32'hFF000000, 32'h00018000, 32'h01000000},
           {32'h0, 32'h01000000, 32'h00020000, 32'h01000000}, 2'd0, 8'h80,
           {32'h0, 32'h80000000, 32'h00030000, 32'h7FFFFFFF}, 4'b0101, w);
      send(rep(32'hFF000000), rep(32'h01000000), 2'd1, 8'h81, rep(32'h80000000), 4'hF, w);
      idle();
      drain();
      chk("sticky_set", ovf_sticky, 1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #1;
      chk("sticky_clear", ovf_sticky, 0);

      // Random backpressure with model-computed expectations.
      bp_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         for (int l = 0; l < 4; l++) begin
            rx = 32'($urandom) >> $urandom_range(4, 20);
            ry = 32'($urandom) >> $urandom_range(4, 20);
            if ($urandom_range(0, 1) == 1) rx = -rx;
            if ($urandom_range(0, 1) == 1) ry = -ry;
            rr = ref_mul(rx, ry, 2'(i % 4));
            va[l*32 +: 32] = rx;
            vb[l*32 +: 32] = ry;
            vr[l*32 +: 32] = rr[31:0];
            vo[l]          = rr[32];
         end
         send(va, vb, 2'(i % 4), 8'(8'hA0 + i), vr, vo, w);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      drain();
      bp_mode = 1'b0;
      repeat (2) @(negedge clk);

      // Asynchronous reset with items in flight.
      for (int i = 0; i < 3; i++) begin
         send(rep(32'h00010000), rep(32'(i + 1)), 2'd0, 8'(8'hC0 + i), rep(32'(i + 1)), 4'h0, w);
      end
      idle();
      #3;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_result", result, 0);
      chk("midrst_tag_out", tag_out, 0);
      chk("midrst_sticky", ovf_sticky, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (10) @(negedge clk);
      #3;
      chk("no_stale_after_rst", seen, 0);
      send(rep(32'h00018000), rep(32'h00020000), 2'd2, 8'h55, rep(32'h00030000), 4'h0, w);
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fx_mul_pipe.md
Name: fx_mul_pipe

Overview:
Parametrised, multi-lane, signed fixed-point multiplier with a valid/ready handshake, selectable rounding, saturation and per-lane overflow reporting. It is the general successor to the single-lane truncating multiplier used across the QMC-LSM datapath for regression, discounting and payoff math. A user tag rides alongside each operation so that burst or interleaved callers can match results to requests.

Parameters:
WIDTH, fpga_cfg_pkg::FP_WIDTH (32), total signed operand/result bits
QFRAC, fpga_cfg_pkg::FP_QFRAC (16), fractional bits of operands and result
LANES, 1, independent multiplies issued per accepted transaction
LATENCY, fpga_cfg_pkg::FP_MUL_LATENCY (3), accept-to-out_valid cycles with no stall; legal range 1..8
TAGW, 8, width of pass-through tag

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands/mode/tag present
in_ready  out  1  block can accept this cycle
a  in  LANES*WIDTH  packed signed operands, lane i = a[i*WIDTH +: WIDTH]
b  in  LANES*WIDTH  packed signed operands
rnd_mode  in  2  fx_rnd_e: 0 TRUNC (floor), 1 HALF_UP, 2 CONVERGENT, 3 reserved (treated as TRUNC)
tag_in  in  TAGW  user tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts
result  out  LANES*WIDTH  packed signed products
ovf  out  LANES  per-lane saturation flag for this result
tag_out  out  TAGW  tag of this result
ovf_sticky  out  1  OR of all ovf since reset or last clear
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async, rst_n low): every stage valid bit = 0; out_valid = 0; result = 0; ovf = 0; tag_out = 0; ovf_sticky = 0. No clock is needed to reach these values. Reset mid-operation discards every in-flight item; none reappears after reset is released.
- Handshake: a transfer occurs when in_valid && in_ready. A result is consumed when out_valid && out_ready. Once asserted, out_valid and its data stay stable until consumed.
- Pipeline: LATENCY register stages with a global enable. in_ready = !out_valid || out_ready, and enable = in_ready. Bubbles are not collapsed. With out_ready held high, one transfer per cycle is sustained and each result appears exactly LATENCY cycles after acceptance, in order.
- Stall: while out_valid && !out_ready, all stages hold their contents and in_ready = 0.
- Stage 0 registers a, b, rnd_mode and tag_in. The full 2*WIDTH signed product is formed in stage 1, or in stage 0 combinationally when LATENCY = 1. Rounding, shifting and saturation complete in the final stage.
- Arithmetic, per lane: p = a*b, signed, 2*WIDTH bits. Let frac = p[QFRAC-1:0] and half = 1 << (QFRAC-1).
  - TRUNC: q = p >>> QFRAC (floor).
  - HALF_UP: q = (p + half) >>> QFRAC.
  - CONVERGENT: as HALF_UP, except when frac == half, where q is the even neighbour of the two.
  - The rounding add is carried out at 2*WIDTH+1 bits so that it cannot wrap.
- Saturation: if q > 2^(WIDTH-1)-1, then result = max and ovf = 1. If q < -2^(WIDTH-1), then result = min and ovf = 1. Otherwise result = q[WIDTH-1:0] and ovf = 0.
- ovf_sticky: set on the cycle a result containing any ovf bit is first presented (the out_valid rising edge or a new item). If ovf_clr and a new overflow occur in the same cycle, the set wins. ovf_clr does not affect the pipeline.
- Lanes share the handshake and the tag. There is no inter-lane dependence.
- No assertion-based overflow checking is required; overflow is an architected output.

Decomposition:
- fpga_cfg_pkg gains:
  - typedef enum logic [1:0] fx_rnd_e {FX_RND_TRUNC, FX_RND_HALF_UP, FX_RND_CONV, FX_RND_RSVD};
  - localparam FP_MUL_LANES_MAX = 8.
  - function fx_sat_round(p, mode) returning {ovf, q}, usable by fxAdd/fxDiv successors.
- One sub-module, fx_mul_lane: a single-lane product/round/saturate datapath with a stage enable. fx_mul_pipe instantiates LANES copies and owns the valid/tag/stall control.

Test Plan:
- WIDTH=32, QFRAC=16, LATENCY=3, out_ready=1: a=0x00018000, b=0x00020000 (1.5*2.0) -> result 0x00030000, ovf=0, exactly 3 cycles after acceptance; 20 back-to-back transfers give in_ready=1 throughout and results in order.
- Rounding, a=0x00000001, b=0x00008000 -> TRUNC 0, HALF_UP 1, CONV 0. With a=0x00000003 -> 1, 2, 2. With a=0xFFFFFFFF -> TRUNC 0xFFFFFFFF, HALF_UP 0, CONV 0.
- Saturation: a=b=0x01000000 -> 0x7FFFFFFF with ovf=1 and ovf_sticky=1. a=0xFF000000, b=0x01000000 -> 0x80000000 with ovf=1. Assert ovf_clr alone -> ovf_sticky=0 the next cycle.
- Backpressure: LANES=4, random in_valid/out_ready, scoreboard on tags -> no loss, duplication or reordering; result and tag_out stay stable while out_ready=0.
- Reset mid-stream: 3 items in flight, drop rst_n asynchronously between clock edges -> out_valid=0 immediately, no stale result after release, and the first post-reset item emerges after LATENCY cycles.
- LATENCY=1 and LATENCY=8 builds pass the first two scenarios, each with the correct latency.
